pio_input_debounce_slave: RTL
=============================

Name: pio_input_debounce_slave

Overview:
- Avalon-MM responder that conditions raw board inputs (push buttons, slide switches) and makes them readable by the PCIe host.
- Sits between the FPGA pins and the system interconnect, in the host-read direction; it complements the host-written output ports for LEDs, hex and cooler.
- Per bit: synchronizes, debounces, captures edges and raises a maskable interrupt.
- Register map is PIO-compatible, so existing host driver code is reused unchanged.

Parameters:
- WIDTH, 16, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, cycles a synchronized bit must hold a new level before it is accepted (>=2). 50000 = 1 ms at 50 MHz.
- EDGE_TYPE, 1, edge that sets capture: 0 = rising, 1 = falling, 2 = any.
- INVERT_MASK, all-zero, per-bit XOR applied after synchronization. Set to 1 for active-low buttons.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pins_in  in  WIDTH  raw asynchronous board inputs.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  read data qualifier.
- irq  out  1  level interrupt to host.

Behaviour:
- Reset (async assert): all registers clear; the clear values are all-zero.
  - Cleared: sync flops, counters, stable, edgecap, irqmask, avs_readdata, avs_readdatavalid, irq.
  - Release of reset must be synchronous to clk.
- Input path, per bit:
  - Two-flop synchronizer, then XOR with INVERT_MASK, giving s.
- Debounce, per bit:
  - counter width = clog2(DEBOUNCE_CYCLES).
  - If s == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= s and counter <= 0.
  - Else: counter++.
  - Net effect: a new level is accepted exactly DEBOUNCE_CYCLES cycles after s first differs, provided it holds without a glitch.
  - Any glitch back to stable restarts the count from 0.
  - Pin-to-stable latency = 2 (sync) + DEBOUNCE_CYCLES cycles.
- Edge capture:
  - An edge is a change of stable matching EDGE_TYPE; it sets edgecap[i] on the cycle after stable changes.
  - Bits are sticky.
  - Writing to address 3 clears every bit where writedata is 1 (write-1-to-clear).
  - Same-cycle set and clear on a bit: the set wins.
- Register map (bits above WIDTH read 0; writes to them are ignored):
  - 0, data: stable, read-only. Writes ignored.
  - 1, direction: reads 0. Writes ignored.
  - 2, irqmask: read/write.
  - 3, edgecapture: read / write-1-to-clear.
- Read timing:
  - Fixed latency 1, no waitrequest.
  - avs_read in cycle N gives avs_readdatavalid = 1 for exactly one cycle, in cycle N+1, with the value sampled in cycle N.
  - Back-to-back reads are supported, one per cycle.
  - avs_readdata holds its last value when valid = 0.
- Write timing:
  - Takes effect at the clock edge of the cycle in which avs_write is 1.
  - avs_read and avs_write asserted together: treat as illegal. The write is performed and the read still returns valid with pre-write data.
- irq:
  - Registered: irq <= |(edgecap & irqmask), i.e. one cycle after the underlying registers.
  - Deasserts one cycle after the clearing write.
- Reset mid-debounce: counters and stable return to 0 immediately. After release, a held-high input must again wait 2 + DEBOUNCE_CYCLES cycles.

Test Plan:
- DEBOUNCE_CYCLES=4, EDGE_TYPE=1, INVERT_MASK=0, WIDTH=16.
  - Drive pins_in = 0x0001 from reset, then read address 0 every cycle.
  - Required: data reads 0x0001 starting 6 cycles after the pin change.
  - Required: edgecap stays 0 (rising edge, falling edge selected).
- Pulse bit 3 high for 3 cycles, then low, repeatedly 5 times.
  - Required: data bit 3 never sets.
  - Required: edgecapture reads 0x0000.
- Debounced bit 2 goes 1 then 0.
  - Required: edgecapture reads 0x0004.
  - Write irqmask = 0x0004: irq goes 1 one cycle later.
  - Write 0x0004 to address 3: edgecapture reads 0, irq drops one cycle after the write.
- Schedule a new falling edge on bit 2 in the same cycle as a clearing write of 0x0004.
  - Required: edgecapture bit 2 remains 1.
  - Required: irq stays 1 if the mask bit is set.
- Issue reads to addresses 0, 1, 2, 3 on consecutive cycles.
  - Required: four consecutive readdatavalid pulses, each one cycle after its read.
  - Required: address 1 returns 0.
  - Required: bits [31:16] are 0 on every read.
- Hold pins_in = 0xFFFF and assert reset for 1 cycle mid-debounce (counter = 2).
  - Required: all outputs are 0 during reset.
  - Required: data reads 0xFFFF exactly 6 cycles after reset release.

Source files
------------

// File: rtl/pio_input_debounce_slave.sv
// ----------------------------------------------------------------------------
// pio_input_debounce_slave
// Avalon-MM responder that conditions raw board inputs (buttons, switches)
// for host reads. Each bit is synchronized, optionally inverted, debounced,
// edge-captured (sticky, write-1-to-clear) and can raise a maskable level IRQ.
// Register map is PIO-compatible:
//   0 data (debounced level, RO)   1 direction (reads 0)
//   2 irqmask (RW)                 3 edgecapture (R / W1C)
// Ports:
//   clk, reset            system clock, async active-high reset
//   pins_in[WIDTH]        raw asynchronous board inputs
//   avs_*                 Avalon-MM slave, fixed read latency 1, no waitrequest
//   irq                   registered level interrupt
// Reset is asserted asynchronously; the reset source is expected to deassert
// synchronously to clk, so no extra release stages are added here (that would
// shift the documented pin-to-data latency after reset).
// ----------------------------------------------------------------------------

// Per-bit input conditioning: 2-flop sync, inversion, debounce.
module pio_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit INV             = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_stable
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1, r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_s;

    assign w_s      = r_sync2 ^ INV;
    assign o_stable = r_stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            // Count consecutive cycles the level differs from the accepted
            // one; any return to the accepted level restarts the count.
            if (w_s == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= w_s;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module pio_input_debounce_slave #(
    parameter int               WIDTH           = 16,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] INVERT_MASK     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             irq
);
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd;
    logic             w_unused;

    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_irqmask;
    logic [31:0]      r_readdata;
    logic             r_readdatavalid;
    logic             r_irq;

    // Write data above WIDTH has no destination.
    assign w_unused = ^avs_writedata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        pio_debounce_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INV             (INVERT_MASK[g])
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .i_pin    (pins_in[g]),
            .o_stable (w_stable[g])
        );
    end

    // Edge of the debounced level; lands in edgecap one cycle after stable moves.
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_stable & ~r_stable_d;
            1:       w_edge = ~w_stable & r_stable_d;
            default: w_edge = w_stable ^ r_stable_d;
        endcase
    end

    assign w_clr = (avs_write && avs_address == 2'd3) ? avs_writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd = '0;
        case (avs_address)
            2'd0:    w_rd[WIDTH-1:0] = w_stable;
            2'd2:    w_rd[WIDTH-1:0] = r_irqmask;
            2'd3:    w_rd[WIDTH-1:0] = r_edgecap;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable_d      <= '0;
            r_edgecap       <= '0;
            r_irqmask       <= '0;
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_irq           <= 1'b0;
        end else begin
            r_stable_d <= w_stable;
            // Set beats a same-cycle clear so no edge is ever lost.
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            if (avs_write && avs_address == 2'd2)
                r_irqmask <= avs_writedata[WIDTH-1:0];
            // Read samples pre-write state when read and write collide.
            if (avs_read)
                r_readdata <= w_rd;
            r_readdatavalid <= avs_read;
            r_irq           <= |(r_edgecap & r_irqmask);
        end
    end

    assign avs_readdata      = r_readdata;
    assign avs_readdatavalid = r_readdatavalid;
    assign irq               = r_irq;
endmodule
